neuron_accumulator: RTL and testbench

NEURON_ACCUMULATOR -- requirements
Module: neuron_accumulator

---
 rtl/neuron_accumulator.sv | 104 ++++++++++
 tb/tb_neuron_accumulator.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_accumulator.sv
// Fixed-point multiply-accumulate for one neuron: bias plus sum of x*w products,
// saturating to the signed DWIDTH range with a sticky saturation flag.
module neuron_accumulator #(
    parameter int DWIDTH = 32,
    parameter int FRAC   = 16,
    parameter int IWIDTH = 64
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic signed [DWIDTH-1:0]        bias,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic signed [DWIDTH-1:0]        x,
    input  logic signed [DWIDTH-1:0]        w,
    input  logic                            in_last,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic signed [DWIDTH-1:0]        sum,
    output logic [$clog2(IWIDTH+1)-1:0]     count,
    output logic                            sat
);

    localparam int CW = $clog2(IWIDTH+1);
    localparam int PW = 2*DWIDTH;

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t                   state;
    logic signed [DWIDTH-1:0] acc;
    logic signed [PW-1:0]     prod;
    logic signed [PW-1:0]     shifted;
    logic signed [PW:0]       total;
    logic                     ovf;
    logic signed [DWIDTH-1:0] acc_next;
    logic                     last_xfer;

    assign sum = acc;

    always_comb begin
        prod     = {{DWIDTH{x[DWIDTH-1]}}, x} * {{DWIDTH{w[DWIDTH-1]}}, w};
        shifted  = prod >>> FRAC;
        total    = {{(DWIDTH+1){acc[DWIDTH-1]}}, acc} + {shifted[PW-1], shifted};
        // In range only if every bit above the result sign matches it
        ovf      = (total[PW:DWIDTH-1] != {(DWIDTH+2){total[DWIDTH-1]}});
        acc_next = total[DWIDTH-1:0];
        if (ovf) begin
            acc_next = total[PW] ? {1'b1, {(DWIDTH-1){1'b0}}}
                                 : {1'b0, {(DWIDTH-1){1'b1}}};
        end
        last_xfer = in_last || (count == CW'(IWIDTH-1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            count     <= '0;
            sat       <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc      <= bias;
                        count    <= '0;
                        sat      <= 1'b0;
                        in_ready <= 1'b1;
                        state    <= ACC;
                    end
                end
                ACC: begin
                    if (in_valid) begin
                        acc   <= acc_next;
                        sat   <= sat | ovf;
                        count <= count + CW'(1);
                        if (last_xfer) begin
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (start) begin
                            acc      <= bias;
                            count    <= '0;
                            sat      <= 1'b0;
                            in_ready <= 1'b1;
                            state    <= ACC;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_accumulator.sv
// Bench for neuron_accumulator: directed and randomized neurons, results checked
// by a scoreboard fed from an arithmetic reference model.
module tb_neuron_accumulator;

    logic               clk = 1'b0;
    logic               rst, start, in_valid, in_ready, in_last;
    logic               out_valid, out_ready, sat;
    logic signed [31:0] bias, x, w, sum;
    logic [6:0]         count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] s;
        int          c;
        logic        st;
    } exp_t;
    exp_t expq[$];

    longint m_acc;
    int     m_cnt;
    bit     m_sat;

    always #5 clk = ~clk;

    neuron_accumulator #(.DWIDTH(32), .FRAC(16), .IWIDTH(64)) dut (
        .clk(clk), .rst(rst), .start(start), .bias(bias),
        .in_valid(in_valid), .in_ready(in_ready), .x(x), .w(w), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .count(count), .sat(sat)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
        end
    endtask

    function automatic void m_start(input logic [31:0] b);
        m_acc = longint'($signed(b));
        m_cnt = 0;
        m_sat = 1'b0;
    endfunction

    // Reference: real product scaled by 2^-FRAC (floor), then clamped to int32
    function automatic bit m_xfer(input logic [31:0] xv, input logic [31:0] wv, input bit last);
        longint p;
        exp_t   e;
        p = longint'($signed(xv)) * longint'($signed(wv));
        m_acc = m_acc + (p >>> 16);
        if (m_acc > 64'sd2147483647) begin
            m_acc = 64'sd2147483647;
            m_sat = 1'b1;
        end else if (m_acc < -64'sd2147483648) begin
            m_acc = -64'sd2147483648;
            m_sat = 1'b1;
        end
        m_cnt++;
        if (last || m_cnt == 64) begin
            e.s  = m_acc[31:0];
            e.c  = m_cnt;
            e.st = m_sat;
            expq.push_back(e);
            return 1'b1;
        end
        return 1'b0;
    endfunction

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: out_valid=1 with nothing pending, sum=0x%0h", sum);
            end else begin
                chk("mon_sum", sum, expq[0].s);
                chk("mon_count", 32'(count), 32'(expq[0].c));
                chk("mon_sat", 32'(sat), 32'(expq[0].st));
                if (out_ready) void'(expq.pop_front());
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [31:0] b);
        start = 1'b1;
        bias = b;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        bias = $urandom;
        m_start(b);
        chk("start_in_ready", 32'(in_ready), 32'd1);
        chk("start_out_valid", 32'(out_valid), 32'd0);
        chk("start_sum", sum, b);
        chk("start_count", 32'(count), 32'd0);
        chk("start_sat", 32'(sat), 32'd0);
    endtask

    task automatic send_pair(input logic [31:0] xv, input logic [31:0] wv, input bit last, input int gap);
        bit done;
        if (gap > 0) begin
            in_last = 1'($urandom_range(0, 1));
            idle(gap);
        end
        in_valid = 1'b1;
        x = xv;
        w = wv;
        in_last = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last = 1'b0;
        x = $urandom;
        w = $urandom;
        done = m_xfer(xv, wv, last);
        chk("xfer_out_valid", 32'(out_valid), 32'(done));
        chk("xfer_in_ready", 32'(in_ready), 32'(!done));
    endtask

    function automatic logic [31:0] rval();
        int v;
        if ($urandom_range(0, 3) == 0) return $urandom;
        v = int'($urandom_range(0, 32'h200000)) - 32'h100000;
        return v;
    endfunction

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; bias = '0; in_valid = 1'b0;
        x = '0; w = '0; in_last = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_sum", sum, 32'd0);
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_sat", 32'(sat), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd0);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        idle(1);
        rst = 1'b0;
        idle(1);

        // basic three-pair neuron
        do_start(32'h00008000);
        send_pair(32'h00010000, 32'h00020000, 1'b0, 0);
        send_pair(32'hFFFF0000, 32'h00008000, 1'b0, 1);
        send_pair(32'h00030000, 32'h00010000, 1'b1, 0);
        chk("basic_sum", sum, 32'h00050000);
        chk("basic_count", 32'(count), 32'd3);
        chk("basic_sat", 32'(sat), 32'd0);
        idle(1);

        // saturation in both directions
        do_start(32'h7FFF0000);
        send_pair(32'h00020000, 32'h00010000, 1'b1, 0);
        chk("sat_hi_sum", sum, 32'h7FFFFFFF);
        chk("sat_hi_flag", 32'(sat), 32'd1);
        idle(1);
        do_start(32'h80010000);
        send_pair(32'hFFFE0000, 32'h00010000, 1'b1, 0);
        chk("sat_lo_sum", sum, 32'h80000000);
        chk("sat_lo_flag", 32'(sat), 32'd1);
        idle(1);

        // maximum count without in_last, then a refused 65th pair
        do_start(32'h0);
        out_ready = 1'b0;
        for (int i = 0; i < 64; i++) send_pair(32'h00010000, 32'h00010000, 1'b0, 0);
        chk("maxcnt_sum", sum, 32'h00400000);
        chk("maxcnt_count", 32'(count), 32'd64);
        in_valid = 1'b1;
        x = 32'h00010000;
        w = 32'h00010000;
        for (int i = 0; i < 3; i++) begin
            idle(1);
            chk("no_65th_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        idle(1);
        chk("maxcnt_release", 32'(out_valid), 32'd0);

        // backpressure in DONE, with start ignored while out_ready=0
        do_start(rval());
        out_ready = 1'b0;
        send_pair(rval(), rval(), 1'b0, 0);
        send_pair(rval(), rval(), 1'b1, 0);
        start = 1'b1;
        bias = 32'h12345678;
        for (int i = 0; i < 5; i++) begin
            idle(1);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        start = 1'b0;
        out_ready = 1'b1;
        idle(1);
        chk("bp_release", 32'(out_valid), 32'd0);
        chk("bp_idle_in_ready", 32'(in_ready), 32'd0);

        // start ignored in ACC, then back-to-back restart and input gaps
        do_start(32'h00020000);
        start = 1'b1;
        bias = 32'h12345678;
        idle(2);
        start = 1'b0;
        chk("acc_ignore_start_sum", sum, m_acc[31:0]);
        chk("acc_ignore_start_count", 32'(count), 32'd0);
        send_pair(32'h00010000, 32'h00010000, 1'b1, 0);
        do_start(32'h00030000);
        send_pair(32'h00020000, 32'h00020000, 1'b0, 0);
        in_last = 1'b1;
        idle(3);
        in_last = 1'b0;
        chk("gap_hold_sum", sum, 32'h00070000);
        chk("gap_hold_count", 32'(count), 32'd1);
        send_pair(32'h00010000, 32'hFFFF0000, 1'b1, 0);
        idle(1);

        // reset in the middle of accumulation
        do_start(rval());
        send_pair(rval(), rval(), 1'b0, 0);
        send_pair(rval(), rval(), 1'b0, 0);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_sum", sum, 32'd0);
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_sat", 32'(sat), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        idle(1);
        rst = 1'b0;
        idle(1);
        do_start(32'h00010000);
        send_pair(32'h0, 32'h0, 1'b1, 0);
        chk("postrst_sum", sum, 32'h00010000);
        chk("postrst_count", 32'(count), 32'd1);
        idle(1);

        // randomized neurons, some restarted back-to-back
        for (int k = 0; k < 40; k++) begin
            do_start(rval());
            n = int'($urandom_range(1, 8));
            for (int i = 0; i < n; i++)
                send_pair(rval(), rval(), i == n - 1, int'($urandom_range(0, 2)));
            if ($urandom_range(0, 1) == 0) begin
                idle(1);
                chk("rand_idle_out_valid", 32'(out_valid), 32'd0);
            end
        end
        idle(3);
        chk("queue_drained", 32'(expq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
